wb_timer: RTL

//   Memory-mapped machine timer peripheral on the furv data bus, a slave beside ram/led/uart.

---
 rtl/wb_timer.sv | 116 +++++++++++
 1 files changed

// File: rtl/wb_timer.sv
// wb_timer - memory-mapped 64-bit machine timer (mtime/mtimecmp) with prescaler and level irq.
module wb_timer #(
  parameter int unsigned PRESCALE = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic [3:0]  sel,
  input  logic        we,
  input  logic        stb,
  input  logic        cyc,
  output logic        ack,
  output logic        irq
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [63:0] mtime_q, mtime_d, cmp_q, cmp_d;
  logic [15:0] presc_q, presc_d;
  logic [31:0] shadow_q, shadow_d, rdata_q, rdata_d;
  logic        en_q, en_d, ie_q, ie_d, ack_q, ack_d, irq_q, irq_d;
  logic        commit, wr, rd, tick, pend;
  logic [31:0] mask;

  assign commit = cyc & stb & ~ack_q;
  assign wr     = commit & we;
  assign rd     = commit & ~we;
  assign tick   = en_q & (presc_q == PRE_LAST);
  assign pend   = (mtime_q >= cmp_q);
  assign mask   = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};

  always_comb begin
    mtime_d  = mtime_q;
    cmp_d    = cmp_q;
    presc_d  = presc_q;
    en_d     = en_q;
    ie_d     = ie_q;
    shadow_d = shadow_q;
    rdata_d  = 32'd0;
    ack_d    = commit;
    irq_d    = ie_q & pend;

    if (en_q) begin
      presc_d = tick ? 16'd0 : presc_q + 16'd1;
      mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    end

    // mtime writes override the tick on the same edge and restart the prescaler
    if (wr) begin
      case (addr)
        3'd0: if (|sel) begin
          mtime_d = {mtime_q[63:32], (mtime_q[31:0] & ~mask) | (data_in & mask)};
          presc_d = 16'd0;
        end
        3'd1: if (|sel) begin
          mtime_d = {(mtime_q[63:32] & ~mask) | (data_in & mask), mtime_q[31:0]};
          presc_d = 16'd0;
        end
        3'd2: cmp_d = {cmp_q[63:32], (cmp_q[31:0] & ~mask) | (data_in & mask)};
        3'd3: cmp_d = {(cmp_q[63:32] & ~mask) | (data_in & mask), cmp_q[31:0]};
        3'd4: if (sel[0]) begin
          en_d = data_in[0];
          ie_d = data_in[1];
          if (data_in[0] && !en_q) presc_d = 16'd0;
        end
        default: ;
      endcase
    end

    if (rd) begin
      case (addr)
        3'd0: begin
          rdata_d  = mtime_q[31:0];
          shadow_d = mtime_q[63:32];
        end
        3'd1:    rdata_d = shadow_q;
        3'd2:    rdata_d = cmp_q[31:0];
        3'd3:    rdata_d = cmp_q[63:32];
        3'd4:    rdata_d = {30'd0, ie_q, en_q};
        3'd5:    rdata_d = {31'd0, pend};
        default: rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q  <= 64'd0;
      cmp_q    <= 64'hFFFF_FFFF_FFFF_FFFF;
      presc_q  <= 16'd0;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      shadow_q <= 32'd0;
      rdata_q  <= 32'd0;
      ack_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      presc_q  <= presc_d;
      en_q     <= en_d;
      ie_q     <= ie_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      irq_q    <= irq_d;
    end
  end

  assign data_out = rdata_q;
  assign ack      = ack_q;
  assign irq      = irq_q;

endmodule
